mips_decode_stage: RTL and testbench

Registered, parametrised decode stage for the MIPS arithmetic subset (add, sub, and, or, nor, xor, addi, andi, ori, xori). It accepts a full 32-bit instruction word over a valid/ready handshake, splits the word into its fields and extends the immediate to DATA_W. It registers the control bundle (rd_src, writeenable, alu_src2, alu_op, except) plus the register indices for the register-file/ALU stage. It also counts illegal instructions and can optionally halt intake on an illegal instruction until software clears it.

---
 rtl/mips_decode_pkg.sv | 48 ++++
 rtl/mips_decode_comb.sv | 48 ++++
 rtl/mips_decode_stage.sv | 115 +++++++++++
 tb/tb_mips_decode_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_decode_pkg.sv
// rtl/mips_decode_pkg.sv - opcode/funct constants, ALU codes and decode control types
package mips_decode_pkg;

  localparam logic [5:0] OP_OTHER0 = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;

  localparam logic [5:0] OP0_ADD = 6'h20;
  localparam logic [5:0] OP0_SUB = 6'h22;
  localparam logic [5:0] OP0_AND = 6'h24;
  localparam logic [5:0] OP0_OR  = 6'h25;
  localparam logic [5:0] OP0_XOR = 6'h26;
  localparam logic [5:0] OP0_NOR = 6'h27;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  typedef enum logic [1:0] {
    SRC2_REG  = 2'd0,
    SRC2_SEXT = 2'd1,
    SRC2_ZEXT = 2'd2
  } src2_e;

  typedef struct packed {
    logic       rd_src;
    logic       writeenable;
    src2_e      alu_src2;
    logic [2:0] alu_op;
    logic       except;
  } ctrl_t;

  localparam ctrl_t CTRL_ILLEGAL = '{
    rd_src: 1'b0, writeenable: 1'b0, alu_src2: SRC2_REG, alu_op: ALU_NONE, except: 1'b1
  };

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage

// File: rtl/mips_decode_comb.sv
// rtl/mips_decode_comb.sv - combinational opcode/funct to control-bundle decoder
module mips_decode_comb
  import mips_decode_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '{rd_src: 1'b0, writeenable: 1'b1, alu_src2: SRC2_REG, alu_op: ALU_NONE, except: 1'b0};
    case (i_opcode)
      OP_OTHER0: begin
        case (i_funct)
          OP0_ADD: o_ctrl.alu_op = ALU_ADD;
          OP0_SUB: o_ctrl.alu_op = ALU_SUB;
          OP0_AND: o_ctrl.alu_op = ALU_AND;
          OP0_OR:  o_ctrl.alu_op = ALU_OR;
          OP0_XOR: o_ctrl.alu_op = ALU_XOR;
          OP0_NOR: o_ctrl.alu_op = ALU_NOR;
          default: o_ctrl = CTRL_ILLEGAL;
        endcase
      end
      OP_ADDI: begin
        o_ctrl.rd_src   = 1'b1;
        o_ctrl.alu_src2 = SRC2_SEXT;
        o_ctrl.alu_op   = ALU_ADD;
      end
      OP_ANDI: begin
        o_ctrl.rd_src   = 1'b1;
        o_ctrl.alu_src2 = SRC2_ZEXT;
        o_ctrl.alu_op   = ALU_AND;
      end
      OP_ORI: begin
        o_ctrl.rd_src   = 1'b1;
        o_ctrl.alu_src2 = SRC2_ZEXT;
        o_ctrl.alu_op   = ALU_OR;
      end
      OP_XORI: begin
        o_ctrl.rd_src   = 1'b1;
        o_ctrl.alu_src2 = SRC2_ZEXT;
        o_ctrl.alu_op   = ALU_XOR;
      end
      default: o_ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mips_decode_stage.sv
// rtl/mips_decode_stage.sv - registered decode stage with handshake, illegal counter and RUN/HALT FSM
module mips_decode_stage
  import mips_decode_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CNT_W          = 8,
  parameter int HALT_ON_EXCEPT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              clear_except,
  output logic              rd_src,
  output logic              writeenable,
  output logic [1:0]        alu_src2,
  output logic [2:0]        alu_op,
  output logic              except,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd_sel,
  output logic [DATA_W-1:0] imm_ext,
  output logic [CNT_W-1:0]  except_count,
  output logic              halted
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_out_valid;
  ctrl_t              r_ctrl;
  logic [4:0]         r_rs;
  logic [4:0]         r_rt;
  logic [4:0]         r_rd_sel;
  logic [DATA_W-1:0]  r_imm;
  logic [CNT_W-1:0]   r_cnt;
  ctrl_t              w_ctrl;
  logic [DATA_W-1:0]  w_imm;
  logic               w_accept;

  mips_decode_comb u_decode (
    .i_opcode (inst[31:26]),
    .i_funct  (inst[5:0]),
    .o_ctrl   (w_ctrl)
  );

  always_comb begin
    w_imm = '0;
    case (w_ctrl.alu_src2)
      SRC2_SEXT: w_imm = DATA_W'($signed(inst[15:0]));
      SRC2_ZEXT: w_imm = DATA_W'(inst[15:0]);
      default:   w_imm = '0;
    endcase
  end

  assign in_ready = reset && (r_state == ST_RUN) && !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_accept && w_ctrl.except && (HALT_ON_EXCEPT != 0)) w_state_next = ST_HALT;
      ST_HALT: if (clear_except) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_out_valid <= 1'b0;
      r_ctrl      <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd_sel    <= '0;
      r_imm       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state <= w_state_next;
      // Bundle registers load only on accept so they stay stable under backpressure.
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_ctrl      <= w_ctrl;
        r_rs        <= inst[25:21];
        r_rt        <= inst[20:16];
        r_rd_sel    <= w_ctrl.rd_src ? inst[20:16] : inst[15:11];
        r_imm       <= w_imm;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && w_ctrl.except && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign rd_src       = r_ctrl.rd_src;
  assign writeenable  = r_ctrl.writeenable;
  assign alu_src2     = r_ctrl.alu_src2;
  assign alu_op       = r_ctrl.alu_op;
  assign except       = r_ctrl.except;
  assign rs           = r_rs;
  assign rt           = r_rt;
  assign rd_sel       = r_rd_sel;
  assign imm_ext      = r_imm;
  assign except_count = r_cnt;
  assign halted       = (r_state == ST_HALT);

endmodule

// File: tb/tb_mips_decode_stage.sv
// tb/tb_mips_decode_stage.sv - directed self-checking bench for mips_decode_stage
module tb_mips_decode_stage;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_SUB  = 32'h0085_3022;
  localparam logic [31:0] I_OR   = 32'h00E8_4825;
  localparam logic [31:0] I_ADDI = 32'h2085_FFFF;
  localparam logic [31:0] I_ANDI = 32'h3085_FFFF;
  localparam logic [31:0] I_BAD  = 32'h0000_0021;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, flush, clear_except;
  logic [31:0] inst;
  logic        rd_src, writeenable, except, halted;
  logic [1:0]  alu_src2;
  logic [2:0]  alu_op;
  logic [4:0]  rs, rt, rd_sel;
  logic [31:0] imm_ext;
  logic [7:0]  except_count;

  logic        b_in_valid, b_in_ready, b_out_valid;
  logic [31:0] b_inst;
  logic        b_rd_src, b_writeenable, b_except, b_halted;
  logic [1:0]  b_alu_src2;
  logic [2:0]  b_alu_op;
  logic [4:0]  b_rs, b_rt, b_rd_sel;
  logic [31:0] b_imm_ext;
  logic [1:0]  b_except_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mips_decode_stage #(.DATA_W(32), .CNT_W(8), .HALT_ON_EXCEPT(1)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .clear_except(clear_except),
    .rd_src(rd_src), .writeenable(writeenable), .alu_src2(alu_src2), .alu_op(alu_op),
    .except(except), .rs(rs), .rt(rt), .rd_sel(rd_sel), .imm_ext(imm_ext),
    .except_count(except_count), .halted(halted)
  );

  mips_decode_stage #(.DATA_W(32), .CNT_W(2), .HALT_ON_EXCEPT(0)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .inst(b_inst),
    .out_valid(b_out_valid), .out_ready(1'b1), .flush(1'b0), .clear_except(1'b0),
    .rd_src(b_rd_src), .writeenable(b_writeenable), .alu_src2(b_alu_src2), .alu_op(b_alu_op),
    .except(b_except), .rs(b_rs), .rt(b_rt), .rd_sel(b_rd_sel), .imm_ext(b_imm_ext),
    .except_count(b_except_count), .halted(b_halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b0; flush = 1'b0; clear_except = 1'b0;
    b_in_valid = 1'b0; b_inst = '0;
    tick(); tick();
    chk("rst_out_valid0", out_valid, 0);
    chk("rst_count", except_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rd_sel", rd_sel, 0);
    chk("rst_imm", imm_ext, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_b_count", b_except_count, 0);

    reset = 1'b1; #1;
    chk("idle_in_ready", in_ready, 1);

    in_valid = 1'b1; inst = I_ADD; out_ready = 1'b1;
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_alu_op", alu_op, 3'b010);
    chk("add_rd_src", rd_src, 0);
    chk("add_src2", alu_src2, 0);
    chk("add_rs", rs, 1);
    chk("add_rt", rt, 2);
    chk("add_rd_sel", rd_sel, 3);
    chk("add_we", writeenable, 1);
    chk("add_except", except, 0);
    chk("add_imm", imm_ext, 0);

    inst = I_ADDI;
    tick();
    chk("addi_src2", alu_src2, 1);
    chk("addi_imm", imm_ext, 32'hFFFF_FFFF);
    chk("addi_rd_sel", rd_sel, 5);
    chk("addi_rs", rs, 4);
    chk("addi_rd_src", rd_src, 1);

    inst = I_ANDI;
    tick();
    chk("andi_src2", alu_src2, 2);
    chk("andi_imm", imm_ext, 32'h0000_FFFF);
    chk("andi_alu_op", alu_op, 3'b100);

    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);

    out_ready = 1'b0; in_valid = 1'b1; inst = I_ADD;
    tick();
    chk("bp_w1_valid", out_valid, 1);
    chk("bp_w1_rd", rd_sel, 3);
    inst = I_SUB; #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_rd", rd_sel, 3);
      chk("bp_hold_op", alu_op, 3'b010);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_w2_rd", rd_sel, 6);
    chk("bp_w2_op", alu_op, 3'b011);
    chk("bp_w2_valid", out_valid, 1);
    inst = I_OR;
    tick();
    chk("bp_w3_rd", rd_sel, 9);
    chk("bp_w3_op", alu_op, 3'b101);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);

    out_ready = 1'b0; in_valid = 1'b1; inst = I_ADD;
    tick();
    chk("fl_pre_valid", out_valid, 1);
    flush = 1'b1; inst = I_SUB; #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    chk("fl_valid", out_valid, 0);
    chk("fl_no_accept_rd", rd_sel, 3);
    flush = 1'b0; in_valid = 1'b0;

    out_ready = 1'b1; in_valid = 1'b1; inst = I_BAD;
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_except", except, 1);
    chk("ill_we", writeenable, 0);
    chk("ill_op", alu_op, 0);
    chk("ill_count", except_count, 1);
    chk("ill_halted", halted, 1);
    chk("ill_in_ready", in_ready, 0);
    inst = I_SUB;
    tick();
    chk("halt_drained", out_valid, 0);
    chk("halt_count", except_count, 1);
    chk("halt_stays", halted, 1);
    in_valid = 1'b0; clear_except = 1'b1;
    tick();
    chk("clr_halted", halted, 0);
    clear_except = 1'b0; #1;
    chk("clr_in_ready", in_ready, 1);
    in_valid = 1'b1; inst = I_OR;
    tick();
    chk("resume_valid", out_valid, 1);
    chk("resume_rd", rd_sel, 9);
    in_valid = 1'b0;

    b_in_valid = 1'b1; b_inst = I_BAD;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_count", b_except_count, (i < 3) ? i + 1 : 3);
      chk("sat_no_halt", b_halted, 0);
    end
    b_in_valid = 1'b0;

    in_valid = 1'b1; inst = I_ADDI; out_ready = 1'b1;
    tick();
    chk("mid_valid", out_valid, 1);
    reset = 1'b0;
    tick();
    chk("mr_valid", out_valid, 0);
    chk("mr_imm", imm_ext, 0);
    chk("mr_rd", rd_sel, 0);
    chk("mr_rs", rs, 0);
    chk("mr_src2", alu_src2, 0);
    chk("mr_we", writeenable, 0);
    chk("mr_count", except_count, 0);
    chk("mr_halted", halted, 0);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_b_count", b_except_count, 0);
    reset = 1'b1; in_valid = 1'b0; #1;
    chk("post_rst_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
